// File: rtl/lifo_stack.sv
// Show-ahead LIFO holding the Fibonacci recursion frame, with full/empty, occupancy and sticky error flags.
// Optional high-water-mark output enabled by defining LIFO_STACK_HWM_EN.
module lifo_stack #(
    parameter int wordsize = 8,
    parameter int DEPTH    = 64,
    parameter int CW       = $clog2(DEPTH+1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [wordsize-1:0] din,
    input  logic                push,
    input  logic                pop,
    input  logic                clr_err,
    output logic [wordsize-1:0] dout,
    output logic                empty,
    output logic                full,
    output logic [CW-1:0]       count,
    output logic                overflow,
`ifdef LIFO_STACK_HWM_EN
    output logic                underflow,
    output logic [CW-1:0]       hwm
`else
    output logic                underflow
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic [wordsize-1:0] mem [DEPTH];

    logic                wr_en;
    logic [AW-1:0]       wr_idx;
    logic [wordsize-1:0] dout_nxt;
    logic [CW-1:0]       cnt_nxt;
    logic                ovf_set;
    logic                unf_set;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    always_comb begin
        wr_en    = 1'b0;
        wr_idx   = '0;
        dout_nxt = dout;
        cnt_nxt  = count;
        ovf_set  = 1'b0;
        unf_set  = 1'b0;
        case ({push, pop})
            2'b10: begin
                if (full) begin
                    ovf_set = 1'b1;
                end else begin
                    wr_en    = 1'b1;
                    wr_idx   = AW'(count);
                    cnt_nxt  = count + CW'(1);
                    dout_nxt = din;
                end
            end
            2'b01: begin
                if (empty) begin
                    unf_set = 1'b1;
                end else begin
                    cnt_nxt = count - CW'(1);
                    // Show-ahead: the entry below the popped one becomes the new top.
                    dout_nxt = (count == CW'(1)) ? '0 : mem[AW'(count - CW'(2))];
                end
            end
            2'b11: begin
                wr_en    = 1'b1;
                dout_nxt = din;
                if (empty) begin
                    wr_idx  = '0;
                    cnt_nxt = CW'(1);
                    unf_set = 1'b1;
                end else begin
                    wr_idx = AW'(count - CW'(1));
                end
            end
            default: ;
        endcase
    end

    // Storage carries no reset; validity is tracked solely by count.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_idx] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count     <= '0;
            dout      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= cnt_nxt;
            dout      <= dout_nxt;
            overflow  <= ovf_set | (overflow  & ~clr_err);
            underflow <= unf_set | (underflow & ~clr_err);
        end
    end

`ifdef LIFO_STACK_HWM_EN
    // Tracks the next count so hwm never lags a rising count, even across clr_err.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            hwm <= '0;
        else if (clr_err || (cnt_nxt > hwm))
            hwm <= cnt_nxt;
    end
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// Directed self-checking bench for lifo_stack (DEPTH=4, 8-bit words).
// Checks hwm as well when built with LIFO_STACK_HWM_EN.
module tb_lifo_stack;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = $clog2(D+1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  din = '0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic          clr_err = 1'b0;
    logic [W-1:0]  dout;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;
`ifdef LIFO_STACK_HWM_EN
    logic [CW-1:0] hwm;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    lifo_stack #(.wordsize(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .din(din), .push(push), .pop(pop), .clr_err(clr_err),
        .dout(dout), .empty(empty), .full(full), .count(count),
`ifdef LIFO_STACK_HWM_EN
        .overflow(overflow), .underflow(underflow), .hwm(hwm)
`else
        .overflow(overflow), .underflow(underflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        n_checks += 6;
        if (count !== 3'd0)  begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        if (empty !== 1'b1)  begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
        if (full !== 1'b0)   begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
        if (dout !== 8'h00)  begin n_fail++; $display("FAIL reset_dout got %h want 00", dout); end
        if (overflow !== 1'b0)  begin n_fail++; $display("FAIL reset_ovf got %b want 0", overflow); end
        if (underflow !== 1'b0) begin n_fail++; $display("FAIL reset_unf got %b want 0", underflow); end
        @(negedge clk);
        rst = 1'b1;
        step();
        step();
        n_checks += 2;
        if (count !== 3'd0) begin n_fail++; $display("FAIL idle_count got %0d want 0", count); end
        if (dout !== 8'h00) begin n_fail++; $display("FAIL idle_dout got %h want 00", dout); end
    endtask

    task automatic test_push_pop();
        logic [W-1:0] pv [3] = '{8'h05, 8'h01, 8'h2A};
        logic [W-1:0] qv [3] = '{8'h01, 8'h05, 8'h00};
        push = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din = pv[i];
            step();
            n_checks++;
            if (dout !== pv[i]) begin n_fail++; $display("FAIL push_dout[%0d] got %h want %h", i, dout, pv[i]); end
        end
        push = 1'b0;
        n_checks++;
        if (count !== 3'd3) begin n_fail++; $display("FAIL push_count got %0d want 3", count); end
        pop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (dout !== qv[i]) begin n_fail++; $display("FAIL pop_dout[%0d] got %h want %h", i, dout, qv[i]); end
        end
        pop = 1'b0;
        n_checks += 2;
        if (empty !== 1'b1) begin n_fail++; $display("FAIL pop_empty got %b want 1", empty); end
        if (count !== 3'd0) begin n_fail++; $display("FAIL pop_count got %0d want 0", count); end
    endtask

    task automatic test_overflow();
        push = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            din = W'(i);
            step();
            if (i == 3) begin
                n_checks++;
                if (full !== 1'b0) begin n_fail++; $display("FAIL full_early got %b want 0", full); end
            end
            if (i == 4) begin
                n_checks += 2;
                if (full !== 1'b1) begin n_fail++; $display("FAIL full_at4 got %b want 1", full); end
                if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %b want 0", overflow); end
            end
        end
        push = 1'b0;
        n_checks += 3;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b want 1", overflow); end
        if (dout !== 8'h04)    begin n_fail++; $display("FAIL ovf_top got %h want 04", dout); end
        if (count !== 3'd4)    begin n_fail++; $display("FAIL ovf_count got %0d want 4", count); end
        pop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (dout !== W'(3 - i)) begin n_fail++; $display("FAIL drain_dout[%0d] got %h want %h", i, dout, W'(3 - i)); end
        end
        pop = 1'b0;
        n_checks += 2;
        if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty got %b want 1", empty); end
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", overflow); end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b want 0", overflow); end
    endtask

    task automatic test_underflow();
        pop = 1'b1;
        step();
        n_checks += 3;
        if (underflow !== 1'b1) begin n_fail++; $display("FAIL unf_set got %b want 1", underflow); end
        if (count !== 3'd0)     begin n_fail++; $display("FAIL unf_count got %0d want 0", count); end
        if (dout !== 8'h00)     begin n_fail++; $display("FAIL unf_dout got %h want 00", dout); end
        pop = 1'b0;
        clr_err = 1'b1;
        step();
        n_checks++;
        if (underflow !== 1'b0) begin n_fail++; $display("FAIL unf_clear got %b want 0", underflow); end
        pop = 1'b1;
        step();
        n_checks++;
        if (underflow !== 1'b1) begin n_fail++; $display("FAIL unf_event_wins got %b want 1", underflow); end
        pop = 1'b0;
        step();
        clr_err = 1'b0;
    endtask

    task automatic test_replace();
        push = 1'b1;
        din = 8'h10;
        step();
        pop = 1'b1;
        din = 8'h77;
        step();
        n_checks += 3;
        if (count !== 3'd1)     begin n_fail++; $display("FAIL repl_count got %0d want 1", count); end
        if (dout !== 8'h77)     begin n_fail++; $display("FAIL repl_dout got %h want 77", dout); end
        if (underflow !== 1'b0) begin n_fail++; $display("FAIL repl_unf got %b want 0", underflow); end
        push = 1'b0;
        step();
        n_checks++;
        if (empty !== 1'b1) begin n_fail++; $display("FAIL repl_pop_empty got %b want 1", empty); end
        push = 1'b1;
        din = 8'h33;
        step();
        push = 1'b0;
        pop = 1'b0;
        n_checks += 3;
        if (count !== 3'd1)     begin n_fail++; $display("FAIL pp_empty_count got %0d want 1", count); end
        if (dout !== 8'h33)     begin n_fail++; $display("FAIL pp_empty_dout got %h want 33", dout); end
        if (underflow !== 1'b1) begin n_fail++; $display("FAIL pp_empty_unf got %b want 1", underflow); end
        pop = 1'b1;
        clr_err = 1'b1;
        step();
        pop = 1'b0;
        clr_err = 1'b0;
        n_checks += 2;
        if (empty !== 1'b1)     begin n_fail++; $display("FAIL pp_drain_empty got %b want 1", empty); end
        if (underflow !== 1'b0) begin n_fail++; $display("FAIL pp_drain_unf got %b want 0", underflow); end
    endtask

    task automatic test_async_reset();
        push = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din = W'(8'hA0 + i);
            step();
        end
        push = 1'b0;
        n_checks += 2;
        if (count !== 3'd3) begin n_fail++; $display("FAIL pre_rst_count got %0d want 3", count); end
        if (dout !== 8'hA2) begin n_fail++; $display("FAIL pre_rst_dout got %h want a2", dout); end
`ifdef LIFO_STACK_HWM_EN
        n_checks++;
        if (hwm !== 3'd3) begin n_fail++; $display("FAIL pre_rst_hwm got %0d want 3", hwm); end
`endif
        #2 rst = 1'b0;
        #1;
        n_checks += 3;
        if (count !== 3'd0) begin n_fail++; $display("FAIL arst_count got %0d want 0", count); end
        if (dout !== 8'h00) begin n_fail++; $display("FAIL arst_dout got %h want 00", dout); end
        if (empty !== 1'b1) begin n_fail++; $display("FAIL arst_empty got %b want 1", empty); end
`ifdef LIFO_STACK_HWM_EN
        n_checks++;
        if (hwm !== 3'd0) begin n_fail++; $display("FAIL arst_hwm got %0d want 0", hwm); end
`endif
        @(negedge clk);
        rst = 1'b1;
        step();
        push = 1'b1;
        din = 8'h0C;
        step();
        din = 8'h0D;
        step();
        push = 1'b0;
        pop = 1'b1;
        step();
        pop = 1'b0;
        n_checks += 2;
        if (count !== 3'd1) begin n_fail++; $display("FAIL post_rst_count got %0d want 1", count); end
        if (dout !== 8'h0C) begin n_fail++; $display("FAIL post_rst_dout got %h want 0c", dout); end
`ifdef LIFO_STACK_HWM_EN
        n_checks++;
        if (hwm !== 3'd2) begin n_fail++; $display("FAIL post_rst_hwm got %0d want 2", hwm); end
`endif
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_overflow();
        test_underflow();
        test_replace();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
